// File: rtl/ram_scan_if.sv
// Command, status and RAM-pin bundle between ram_scan_ctrl and its environment.
// The slave modport is the controller's side; master is the host/RAM side.
interface ram_scan_if #(
    parameter int DW = 16,
    parameter int AW = 7
);
    logic          start;
    logic          mode;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_value;
    logic [AW-1:0] max_adrs;
    logic [AW-1:0] adrs;
    logic [DW-1:0] wdata;
    logic          data_en;
    logic          _ce;
    logic          _we;
    logic          _oe;
    logic [DW-1:0] rdata;

    modport master (
        output start, mode, fill_data, rdata,
        input  busy, done, max_value, max_adrs, adrs, wdata, data_en, _ce, _we, _oe
    );

    modport slave (
        input  start, mode, fill_data, rdata,
        output busy, done, max_value, max_adrs, adrs, wdata, data_en, _ce, _we, _oe
    );
endinterface

// File: rtl/ram_scan_ctrl.sv
// Fill / max-scan sequencer for a 128x16 asynchronous RAM; all outputs registered.
// state     | meaning
// IDLE      | waiting for start, RAM deselected
// WR_SETUP  | address/data settle, _ce low, _we high
// WR_STROBE | _we low for one cycle, then next address
// RD_ADDR   | one read address per cycle, _oe low
// RD_LAST   | hold last address so its sample reaches the compare stage
// DONE      | one-cycle done pulse, RAM deselected
module ram_scan_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 7,
    parameter int DEPTH = 128
) (
    input  logic       clk,
    input  logic       _rst,
    ram_scan_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_STROBE, RD_ADDR, RD_LAST, DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADRS = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] adrs_q, adrs_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          den_q, den_d;
    logic          ce_q, ce_d;
    logic          we_q, we_d;
    logic          oe_q, oe_d;
    logic [DW-1:0] max_value_q, max_value_d;
    logic [AW-1:0] max_adrs_q, max_adrs_d;
    logic [DW-1:0] cap_data_q;
    logic [AW-1:0] cap_adrs_q;
    logic          cap_vld_q;

    always_comb begin
        state_d = state_q;
        adrs_d  = adrs_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    adrs_d = '0;
                    if (!bus.mode) begin
                        wdata_d = bus.fill_data;
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: begin
                if (adrs_q == LAST_ADRS) begin
                    state_d = DONE;
                end else begin
                    adrs_d  = adrs_q + 1'b1;
                    state_d = WR_SETUP;
                end
            end
            RD_ADDR: begin
                if (adrs_q == LAST_ADRS) state_d = RD_LAST;
                else                     adrs_d  = adrs_q + 1'b1;
            end
            RD_LAST: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin levels are decoded from the next state so they register together with it.
    always_comb begin
        ce_d   = 1'b1;
        we_d   = 1'b1;
        oe_d   = 1'b1;
        den_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            WR_SETUP: begin
                ce_d = 1'b0; den_d = 1'b1; busy_d = 1'b1;
            end
            WR_STROBE: begin
                ce_d = 1'b0; we_d = 1'b0; den_d = 1'b1; busy_d = 1'b1;
            end
            RD_ADDR, RD_LAST: begin
                ce_d = 1'b0; oe_d = 1'b0; busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Address 0 is always the first sample of a scan, so it loads unconditionally.
    always_comb begin
        max_value_d = max_value_q;
        max_adrs_d  = max_adrs_q;
        if (cap_vld_q && ((cap_adrs_q == '0) || (cap_data_q > max_value_q))) begin
            max_value_d = cap_data_q;
            max_adrs_d  = cap_adrs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state_q     <= IDLE;
            adrs_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            den_q       <= 1'b0;
            ce_q        <= 1'b1;
            we_q        <= 1'b1;
            oe_q        <= 1'b1;
            max_value_q <= '0;
            max_adrs_q  <= '0;
            cap_data_q  <= '0;
            cap_adrs_q  <= '0;
            cap_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adrs_q      <= adrs_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            den_q       <= den_d;
            ce_q        <= ce_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            max_value_q <= max_value_d;
            max_adrs_q  <= max_adrs_d;
            cap_data_q  <= bus.rdata;
            cap_adrs_q  <= adrs_q;
            cap_vld_q   <= (state_q == RD_ADDR);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_value = max_value_q;
    assign bus.max_adrs  = max_adrs_q;
    assign bus.adrs      = adrs_q;
    assign bus.wdata     = wdata_q;
    assign bus.data_en   = den_q;
    assign bus._ce       = ce_q;
    assign bus._we       = we_q;
    assign bus._oe       = oe_q;
endmodule
